// File: rtl/reply_sched_pkg.sv
// Shared state encoding, timing defaults and Miller symbol-length lookup for reply_scheduler.
package reply_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_T1 = 2'd1,
        ST_ACTIVE  = 2'd2,
        ST_T2_WAIT = 2'd3
    } state_t;

    localparam int DEF_DIV_W     = 8;
    localparam int DEF_T1_TPRI   = 10;
    localparam int DEF_WDOG_SYMS = 1023;
    localparam int DEF_T2_TPRI   = 20;

    localparam int WDOG_W = 10;
    localparam int TCNT_W = 16;

    // Miller index m gives 2^m BLF periods per symbol.
    function automatic logic [3:0] sym_len(input logic [1:0] m);
        return 4'd1 << m;
    endfunction

endpackage

// File: rtl/blf_tick_gen.sv
// BLF period divider and Miller symbol prescaler with synchronous restarts.
module blf_tick_gen
    import reply_sched_pkg::*;
#(
    parameter int DIV_W = DEF_DIV_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             restart_blf,
    input  logic             restart_sym,
    input  logic [DIV_W-1:0] div,
    input  logic [1:0]       m,
    output logic             blf_tick,
    output logic             sym_tick
);

    logic [DIV_W-1:0] blf_cnt;
    logic [2:0]       pre_cnt;
    logic [2:0]       pre_top;

    assign pre_top  = 3'(sym_len(m) - 4'd1);
    assign blf_tick = en && (blf_cnt == div - DIV_W'(1));
    assign sym_tick = blf_tick && (pre_cnt == pre_top);

    // Counters sit at zero while idle; restarts take priority over counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blf_cnt <= '0;
            pre_cnt <= '0;
        end else begin
            if (restart_blf || !en || blf_tick) begin
                blf_cnt <= '0;
            end else begin
                blf_cnt <= blf_cnt + DIV_W'(1);
            end

            if (restart_sym || !en) begin
                pre_cnt <= '0;
            end else if (blf_tick) begin
                pre_cnt <= (pre_cnt == pre_top) ? 3'd0 : pre_cnt + 3'd1;
            end
        end
    end

endmodule

// File: rtl/reply_scheduler.sv
// Backscatter reply sequencer: T1 turnaround, symbol strobes, clear/abort/watchdog handling.
// Optional T2 window timer is enabled by defining REPLY_T2_TIMER_EN.
module reply_scheduler
    import reply_sched_pkg::*;
#(
    parameter int DIV_W     = DEF_DIV_W,
    parameter int T1_TPRI   = DEF_T1_TPRI,
    parameter int WDOG_SYMS = DEF_WDOG_SYMS,
    parameter int T2_TPRI   = DEF_T2_TPRI
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_cmd_done_dec,
    input  logic             i_reply_req_cu,
    input  logic [DIV_W-1:0] i_blf_div,
    input  logic [1:0]       i_m_dec,
    input  logic             i_done_ocu,
    input  logic             i_abort_cu,
    output logic             o_datarate_ocu,
    output logic             o_clear_ocu,
    output logic             o_reply_active,
    output logic             o_busy,
    output logic             o_timeout,
    output logic             o_t2_expired
);

    state_t            state;
    logic [DIV_W-1:0]  div_q;
    logic [1:0]        m_q;
    logic [TCNT_W-1:0] t1_cnt;
    logic [WDOG_W-1:0] wdog;
    logic              clr_pend;

    logic blf_tick;
    logic sym_tick;
    logic live;
    logic enter_t1;
    logic t1_done;
    logic sym_ok;
    logic wdog_hit;
    logic want_clear;
    logic [DIV_W-1:0] div_lat;

    assign div_lat  = (i_blf_div < DIV_W'(2)) ? DIV_W'(2) : i_blf_div;
    assign live     = (state == ST_WAIT_T1) || (state == ST_ACTIVE);
    assign enter_t1 = i_cmd_done_dec && i_reply_req_cu && !i_abort_cu;
    assign t1_done  = (state == ST_WAIT_T1) && blf_tick && (t1_cnt == '0)
                      && !i_abort_cu && !i_cmd_done_dec;
    assign sym_ok   = (state == ST_ACTIVE) && sym_tick
                      && !i_abort_cu && !i_cmd_done_dec && !i_done_ocu;
    assign wdog_hit = sym_ok && (wdog == WDOG_W'(WDOG_SYMS - 1));

    // The symbol that would exceed the watchdog budget is swallowed, not strobed.
    assign o_datarate_ocu = sym_ok && !wdog_hit;
    assign want_clear     = enter_t1 || (live && (i_abort_cu || i_cmd_done_dec)) || wdog_hit;

    assign o_busy         = (state != ST_IDLE);
    assign o_reply_active = (state == ST_ACTIVE);

    blf_tick_gen #(
        .DIV_W (DIV_W)
    ) u_tick_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (o_busy),
        .restart_blf (enter_t1),
        .restart_sym (t1_done),
        .div         (div_q),
        .m           (m_q),
        .blf_tick    (blf_tick),
        .sym_tick    (sym_tick)
    );

`ifdef REPLY_T2_TIMER_EN
    logic [TCNT_W-1:0] t2_cnt;
`else
    logic unused_t2;
    assign unused_t2    = T2_TPRI[0];
    assign o_t2_expired = 1'b0;
`endif

    // Abort and reader commands preempt every state; otherwise each state runs its own timer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            div_q       <= DIV_W'(2);
            m_q         <= 2'd0;
            t1_cnt      <= '0;
            wdog        <= '0;
            clr_pend    <= 1'b0;
            o_clear_ocu <= 1'b0;
            o_timeout   <= 1'b0;
`ifdef REPLY_T2_TIMER_EN
            t2_cnt       <= '0;
            o_t2_expired <= 1'b0;
`endif
        end else begin
            // A pending clear absorbs any further request, so pulses never abut.
            clr_pend    <= want_clear && !clr_pend;
            o_clear_ocu <= clr_pend;
`ifdef REPLY_T2_TIMER_EN
            o_t2_expired <= 1'b0;
`endif
            if (i_cmd_done_dec) begin
                div_q     <= div_lat;
                m_q       <= i_m_dec;
                o_timeout <= 1'b0;
            end

            if (i_abort_cu) begin
                state <= ST_IDLE;
            end else if (i_cmd_done_dec) begin
                if (i_reply_req_cu) begin
                    state  <= ST_WAIT_T1;
                    t1_cnt <= TCNT_W'(T1_TPRI - 1);
                end else begin
                    state <= ST_IDLE;
                end
            end else begin
                case (state)
                    ST_IDLE: begin
                        state <= ST_IDLE;
                    end
                    ST_WAIT_T1: begin
                        if (blf_tick) begin
                            if (t1_cnt == '0) begin
                                state <= ST_ACTIVE;
                                wdog  <= '0;
                            end else begin
                                t1_cnt <= t1_cnt - TCNT_W'(1);
                            end
                        end
                    end
                    ST_ACTIVE: begin
                        if (i_done_ocu) begin
`ifdef REPLY_T2_TIMER_EN
                            state  <= ST_T2_WAIT;
                            t2_cnt <= TCNT_W'(T2_TPRI - 1);
`else
                            state <= ST_IDLE;
`endif
                        end else if (wdog_hit) begin
                            state     <= ST_IDLE;
                            o_timeout <= 1'b1;
                        end else if (sym_tick) begin
                            wdog <= wdog + WDOG_W'(1);
                        end
                    end
`ifdef REPLY_T2_TIMER_EN
                    ST_T2_WAIT: begin
                        if (blf_tick) begin
                            if (t2_cnt == '0) begin
                                state        <= ST_IDLE;
                                o_t2_expired <= 1'b1;
                            end else begin
                                t2_cnt <= t2_cnt - TCNT_W'(1);
                            end
                        end
                    end
`endif
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_reply_scheduler.sv
// Scoreboard bench for reply_scheduler: expected strobe/clear cycles are queued and matched by a monitor.
module tb_reply_scheduler;

`ifdef REPLY_T2_TIMER_EN
    localparam bit T2_ON = 1'b1;
`else
    localparam bit T2_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_done = 1'b0;
    logic       reply_req = 1'b0;
    logic [7:0] blf_div = 8'd0;
    logic [1:0] m_dec = 2'd0;
    logic       done_ocu = 1'b0;
    logic       abort_cu = 1'b0;
    logic       datarate;
    logic       clear_ocu;
    logic       reply_active;
    logic       busy;
    logic       timeout;
    logic       t2_expired;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int strobe_q[$];
    int clear_q[$];

    reply_scheduler #(
        .DIV_W     (8),
        .T1_TPRI   (10),
        .WDOG_SYMS (16),
        .T2_TPRI   (20)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_cmd_done_dec (cmd_done),
        .i_reply_req_cu (reply_req),
        .i_blf_div      (blf_div),
        .i_m_dec        (m_dec),
        .i_done_ocu     (done_ocu),
        .i_abort_cu     (abort_cu),
        .o_datarate_ocu (datarate),
        .o_clear_ocu    (clear_ocu),
        .o_reply_active (reply_active),
        .o_busy         (busy),
        .o_timeout      (timeout),
        .o_t2_expired   (t2_expired)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitCycle(input int target);
        while (cyc < target) tick();
    endtask

    task automatic atCycle(input int target);
        waitCycle(target);
        @(negedge clk);
    endtask

    // Drives one cycle of inputs; pulse inputs drop again afterwards.
    task automatic applyStimulus(input bit cmd, input bit req, input logic [7:0] div,
                                 input logic [1:0] m, input bit done, input bit abort);
        cmd_done  = cmd;
        reply_req = req;
        blf_div   = div;
        m_dec     = m;
        done_ocu  = done;
        abort_cu  = abort;
        tick();
        cmd_done  = 1'b0;
        done_ocu  = 1'b0;
        abort_cu  = 1'b0;
    endtask

    task automatic pushStrobes(input int first, input int period, input int count);
        for (int k = 0; k < count; k++) strobe_q.push_back(first + k * period);
    endtask

    // Monitor: every strobe and clear pulse must match the front of its queue.
    always @(negedge clk) begin
        int exp_c;
        if (rst_n) begin
            while (strobe_q.size() > 0 && strobe_q[0] < cyc) begin
                exp_c = strobe_q.pop_front();
                checkOutput("missed_strobe", cyc, exp_c);
            end
            while (clear_q.size() > 0 && clear_q[0] < cyc) begin
                exp_c = clear_q.pop_front();
                checkOutput("missed_clear", cyc, exp_c);
            end
            if (datarate) begin
                if (strobe_q.size() == 0) begin
                    checkOutput("unexpected_strobe", {31'd0, datarate}, 0);
                end else begin
                    exp_c = strobe_q.pop_front();
                    checkOutput("strobe_cycle", cyc, exp_c);
                end
            end
            if (clear_ocu) begin
                if (clear_q.size() == 0) begin
                    checkOutput("unexpected_clear", {31'd0, clear_ocu}, 0);
                end else begin
                    exp_c = clear_q.pop_front();
                    checkOutput("clear_cycle", cyc, exp_c);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL global_timeout simulation did not finish");
        $fatal(1, "[TB] time limit reached");
    end

    initial begin
        int n;
        int mid;
        int d;

        repeat (3) tick();
        @(negedge clk);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_active", reply_active, 0);
        checkOutput("reset_timeout", timeout, 0);
        checkOutput("reset_clear", clear_ocu, 0);
        checkOutput("reset_datarate", datarate, 0);
        checkOutput("reset_t2", t2_expired, 0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();

        // Basic reply: div=4, m=0.
        n = cyc;
        clear_q.push_back(n + 2);
        pushStrobes(n + 44, 4, 5);
        applyStimulus(1, 1, 8'd4, 2'd0, 0, 0);
        atCycle(n + 1);
        checkOutput("basic_busy", busy, 1);
        checkOutput("basic_active_t1", reply_active, 0);
        atCycle(n + 40);
        checkOutput("basic_active_before", reply_active, 0);
        atCycle(n + 41);
        checkOutput("basic_active_entry", reply_active, 1);
        waitCycle(n + 61);
        applyStimulus(0, 1, 8'd4, 2'd0, 1, 0);
        atCycle(n + 62);
        checkOutput("basic_busy_after_done", busy, T2_ON);
        checkOutput("basic_active_after_done", reply_active, 0);
        atCycle(n + 140);
        checkOutput("t2_before_expiry", t2_expired, 0);
        atCycle(n + 141);
        checkOutput("t2_expiry", t2_expired, T2_ON);
        checkOutput("t2_busy_after", busy, 0);
        atCycle(n + 142);
        checkOutput("t2_pulse_width", t2_expired, 0);

        // Miller spacing: div=6, m=2 gives 24-cycle symbols.
        n = cyc + 200;
        waitCycle(n);
        clear_q.push_back(n + 2);
        pushStrobes(n + 84, 24, 3);
        applyStimulus(1, 1, 8'd6, 2'd2, 0, 0);
        waitCycle(n + 133);
        applyStimulus(0, 1, 8'd6, 2'd2, 1, 0);
        atCycle(n + 134);
        checkOutput("miller_busy_after_done", busy, T2_ON);

        // New command inside the would-be T2 window, then abort during T1.
        d = n + 133;
        waitCycle(d + 40);
        clear_q.push_back(d + 42);
        applyStimulus(1, 1, 8'd2, 2'd0, 0, 0);
        atCycle(d + 41);
        checkOutput("t2win_cmd_busy", busy, 1);
        waitCycle(d + 45);
        clear_q.push_back(d + 47);
        applyStimulus(0, 1, 8'd2, 2'd0, 0, 1);
        atCycle(d + 46);
        checkOutput("t2win_abort_busy", busy, 0);
        atCycle(d + 80);
        checkOutput("t2win_no_expiry", t2_expired, 0);

        // Clamp: div=0 behaves as div=2; done coinciding with a symbol tick wins.
        n = cyc + 200;
        waitCycle(n);
        clear_q.push_back(n + 2);
        pushStrobes(n + 22, 2, 4);
        applyStimulus(1, 1, 8'd0, 2'd0, 0, 0);
        waitCycle(n + 30);
        applyStimulus(0, 1, 8'd0, 2'd0, 1, 0);
        atCycle(n + 31);
        checkOutput("clamp_busy_after_done", busy, T2_ON);

        // Command without reply request leaves the block idle and unclear.
        n = cyc + 200;
        waitCycle(n);
        applyStimulus(1, 0, 8'd5, 2'd0, 0, 0);
        atCycle(n + 1);
        checkOutput("noreply_busy", busy, 0);
        atCycle(n + 2);
        checkOutput("noreply_clear", clear_ocu, 0);

        // Reader interrupt mid-reply restarts T1 with the new divider.
        n = cyc + 200;
        waitCycle(n);
        clear_q.push_back(n + 2);
        pushStrobes(n + 44, 4, 2);
        applyStimulus(1, 1, 8'd4, 2'd0, 0, 0);
        mid = n + 50;
        waitCycle(mid);
        clear_q.push_back(mid + 2);
        pushStrobes(mid + 88, 8, 3);
        applyStimulus(1, 1, 8'd8, 2'd0, 0, 0);
        atCycle(mid + 1);
        checkOutput("intr_busy", busy, 1);
        checkOutput("intr_active", reply_active, 0);
        waitCycle(mid + 105);
        applyStimulus(0, 1, 8'd8, 2'd0, 1, 0);
        atCycle(mid + 106);
        checkOutput("intr_busy_after_done", busy, T2_ON);

        // Abort together with a command: abort wins.
        n = cyc + 200;
        waitCycle(n);
        clear_q.push_back(n + 2);
        pushStrobes(n + 44, 4, 1);
        applyStimulus(1, 1, 8'd4, 2'd0, 0, 0);
        waitCycle(n + 46);
        clear_q.push_back(n + 48);
        applyStimulus(1, 1, 8'd4, 2'd0, 0, 1);
        atCycle(n + 47);
        checkOutput("abortcmd_busy", busy, 0);
        checkOutput("abortcmd_clear_early", clear_ocu, 0);
        atCycle(n + 48);
        checkOutput("abortcmd_clear", clear_ocu, 1);

        // Watchdog: 15 strobes, then forced exit with a clear and sticky timeout.
        n = cyc + 200;
        waitCycle(n);
        clear_q.push_back(n + 2);
        pushStrobes(n + 22, 2, 15);
        clear_q.push_back(n + 54);
        applyStimulus(1, 1, 8'd2, 2'd0, 0, 0);
        atCycle(n + 40);
        checkOutput("wdog_timeout_before", timeout, 0);
        atCycle(n + 52);
        checkOutput("wdog_busy_last", busy, 1);
        atCycle(n + 53);
        checkOutput("wdog_busy_after", busy, 0);
        checkOutput("wdog_timeout_set", timeout, 1);
        atCycle(n + 70);
        checkOutput("wdog_timeout_held", timeout, 1);
        waitCycle(n + 71);
        applyStimulus(1, 0, 8'd2, 2'd0, 0, 0);
        atCycle(n + 72);
        checkOutput("wdog_timeout_cleared", timeout, 0);

        waitCycle(cyc + 10);
        @(negedge clk);
        checkOutput("strobe_queue_empty", strobe_q.size(), 0);
        checkOutput("clear_queue_empty", clear_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
